// File: rtl/func_sched_pkg.sv
// func_sched shared types and constants.
// State encoding, port count and timeout counter sizing.
package func_sched_pkg;

    localparam int NPORT       = 2;
    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACC,
        WAIT_DONE,
        DONE
    } state_e;

endpackage

// File: rtl/func_sched_if.sv
// Bus between the scheduler and the shared func unit.
// master = scheduler side, slave = func unit side.
interface func_sched_if;

    logic [7:0]  fu_a_bo;
    logic [7:0]  fu_b_bo;
    logic        fu_start_o;
    logic        fu_busy_i;
    logic [15:0] fu_y_bi;

    modport master (
        output fu_a_bo,
        output fu_b_bo,
        output fu_start_o,
        input  fu_busy_i,
        input  fu_y_bi
    );

    modport slave (
        input  fu_a_bo,
        input  fu_b_bo,
        input  fu_start_o,
        output fu_busy_i,
        output fu_y_bi
    );

endinterface

// File: rtl/func_sched_rr.sv
// Two-way round-robin picker.
// On a tie the port that was not granted last wins.
module func_sched_rr
    import func_sched_pkg::*;
(
    input  logic [NPORT-1:0] req_i,
    input  logic             last_i,
    output logic [NPORT-1:0] gnt_o
);

    // one-hot grant from request vector and last winner
    always_comb begin
        gnt_o = '0;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/func_sched.sv
// Two-port scheduler in front of one shared func unit.
// Optional wait timeout: define FUNC_SCHED_TIMEOUT_EN.
module func_sched
    import func_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic [7:0]  a0_bi,
    input  logic [7:0]  b0_bi,
    input  logic [7:0]  a1_bi,
    input  logic [7:0]  b1_bi,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic [15:0] y0_bo,
    output logic [15:0] y1_bo,
    output logic        err0_o,
    output logic        err1_o,
    output logic        busy_o,
    func_sched_if.master fu
);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        sel_q, sel_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] y0_q, y0_d;
    logic [15:0] y1_q, y1_d;
    logic [1:0]  gnt;

`ifdef FUNC_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    func_sched_rr u_rr (
        .req_i  ({req1_i, req0_i}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    // next state, grant latch, result capture
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
`ifdef FUNC_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    sel_d   = gnt[1];
                    last_d  = gnt[1];
                    a_d     = gnt[1] ? a1_bi : a0_bi;
                    b_d     = gnt[1] ? b1_bi : b0_bi;
                    state_d = START;
`ifdef FUNC_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            START: begin
                state_d = WAIT_ACC;
`ifdef FUNC_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_ACC: begin
                if (fu.fu_busy_i) begin
                    state_d = WAIT_DONE;
`ifdef FUNC_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            WAIT_DONE: begin
                if (!fu.fu_busy_i) begin
                    if (sel_q) y1_d = fu.fu_y_bi;
                    else       y0_d = fu.fu_y_bi;
                    state_d = DONE;
`ifdef FUNC_SCHED_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state registers; port 0 wins the first tie
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
        end
    end

`ifdef FUNC_SCHED_TIMEOUT_EN
    // wait-state timeout counter and abort flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err0_o = ack0_o & err_q;
    assign err1_o = ack1_o & err_q;
`else
    assign err0_o = 1'b0;
    assign err1_o = 1'b0;
`endif

    assign ack0_o        = (state_q == DONE) & ~sel_q;
    assign ack1_o        = (state_q == DONE) &  sel_q;
    assign busy_o        = (state_q != IDLE);
    assign y0_bo         = y0_q;
    assign y1_bo         = y1_q;
    assign fu.fu_a_bo    = a_q;
    assign fu.fu_b_bo    = b_q;
    assign fu.fu_start_o = (state_q == START);

endmodule

// File: tb/tb_func_sched.sv
// Directed bench for func_sched with a behavioural func unit.
// The func unit computes a^2 + floor(cbrt(b)) after fu_lat cycles.
module tb_func_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [7:0]  a0, b0, a1, b1;
    logic        ack0, ack1, err0, err1, busy;
    logic [15:0] y0, y1;

    int nvec = 0;
    int nerr = 0;

    int fu_lat   = 2;
    bit fu_dead  = 1'b0;
    int fcnt;

    int n_start = 0;
    int n_ack0  = 0;
    int n_ack1  = 0;
    int n_err0  = 0;

    func_sched_if fu_if ();

    func_sched #(.TIMEOUT(10)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .req0_i (req0),
        .req1_i (req1),
        .a0_bi  (a0),
        .b0_bi  (b0),
        .a1_bi  (a1),
        .b1_bi  (b1),
        .ack0_o (ack0),
        .ack1_o (ack1),
        .y0_bo  (y0),
        .y1_bo  (y1),
        .err0_o (err0),
        .err1_o (err1),
        .busy_o (busy),
        .fu     (fu_if)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fu_model(logic [7:0] a,
                                             logic [7:0] b);
        logic [15:0] r;
        r = 16'd0;
        for (int i = 0; i < 8; i++)
            if (i * i * i <= int'(b)) r = 16'(i);
        return 16'({8'd0, a} * {8'd0, a}) + r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            fu_if.fu_busy_i <= 1'b0;
            fu_if.fu_y_bi   <= 16'd0;
            fcnt            <= 0;
        end else if (!fu_dead) begin
            if (fu_if.fu_start_o) begin
                fu_if.fu_busy_i <= 1'b1;
                fu_if.fu_y_bi   <= fu_model(fu_if.fu_a_bo,
                                            fu_if.fu_b_bo);
                fcnt            <= fu_lat;
            end else if (fu_if.fu_busy_i) begin
                if (fcnt == 0) fu_if.fu_busy_i <= 1'b0;
                else           fcnt <= fcnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (fu_if.fu_start_o) n_start++;
        if (ack0) n_ack0++;
        if (ack1) n_ack1++;
        if (err0) n_err0++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic wait_port(input int port, output bit got,
                             output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            step();
            cyc++;
            if ((port == 0 && ack0) || (port == 1 && ack1))
                got = 1'b1;
        end
    endtask

    task automatic wait_any(output int port, output bit got);
        int cyc;
        got  = 1'b0;
        port = -1;
        cyc  = 0;
        while (!got && cyc < 200) begin
            step();
            cyc++;
            if (ack0 || ack1) begin
                got  = 1'b1;
                port = ack1 ? 1 : 0;
            end
        end
    endtask

    task automatic wait_start(output bit got);
        int cyc;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 50) begin
            step();
            cyc++;
            if (fu_if.fu_start_o) got = 1'b1;
        end
    endtask

    initial begin
        bit got;
        int cyc, port, s0, k0, k1;

        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        a0 = 8'd0; b0 = 8'd0;
        a1 = 8'd0; b1 = 8'd0;
        step();
        step();
        chk("rst_ctl", {26'd0, ack0, ack1, err0, err1, busy,
                        fu_if.fu_start_o}, 32'd0);
        chk("rst_y0", {16'd0, y0}, 32'd0);
        chk("rst_y1", {16'd0, y1}, 32'd0);
        chk("rst_fu_ab", {16'd0, fu_if.fu_a_bo, fu_if.fu_b_bo}, 32'd0);
        rst = 1'b0;
        step();

        // single request on port 0
        s0 = n_start;
        k0 = n_ack0;
        a0 = 8'd3; b0 = 8'd27; req0 = 1'b1;
        wait_port(0, got, cyc);
        req0 = 1'b0;
        chk("p0_ack", {31'd0, got}, 32'd1);
        chk("p0_y0", {16'd0, y0}, 32'd12);
        chk("p0_err", {31'd0, err0}, 32'd0);
        step();
        step();
        chk("p0_start_once", n_start - s0, 32'd1);
        chk("p0_ack_once", n_ack0 - k0, 32'd1);
        chk("p0_idle", {31'd0, busy}, 32'd0);

        // simultaneous pair after reset: port 0 first
        rst = 1'b1;
        step();
        rst = 1'b0;
        a0 = 8'd2; b0 = 8'd8;
        a1 = 8'd4; b1 = 8'd64;
        req0 = 1'b1; req1 = 1'b1;
        wait_any(port, got);
        chk("pair1_first", port, 32'd0);
        chk("pair1_y0", {16'd0, y0}, 32'd6);
        req0 = 1'b0;
        wait_port(1, got, cyc);
        req1 = 1'b0;
        chk("pair1_ack1", {31'd0, got}, 32'd1);
        chk("pair1_y1", {16'd0, y1}, 32'd20);
        chk("pair1_y0_held", {16'd0, y0}, 32'd6);
        step();

        // port 0 alone, so port 1 owns the next tie
        a0 = 8'd3; b0 = 8'd27; req0 = 1'b1;
        wait_port(0, got, cyc);
        req0 = 1'b0;
        chk("solo0_y0", {16'd0, y0}, 32'd12);
        step();

        // second simultaneous pair: port 1 first
        a0 = 8'd1; b0 = 8'd1;
        a1 = 8'd5; b1 = 8'd125;
        req0 = 1'b1; req1 = 1'b1;
        wait_any(port, got);
        chk("pair2_first", port, 32'd1);
        chk("pair2_y1", {16'd0, y1}, 32'd30);
        req1 = 1'b0;
        wait_port(0, got, cyc);
        req0 = 1'b0;
        chk("pair2_y0", {16'd0, y0}, 32'd2);
        step();

        // full-scale operands on port 1
        k0 = n_ack0;
        a1 = 8'd255; b1 = 8'd255; req1 = 1'b1;
        wait_port(1, got, cyc);
        req1 = 1'b0;
        chk("max_y1", {16'd0, y1}, 32'd65031);
        chk("max_y0_held", {16'd0, y0}, 32'd2);
        chk("max_no_ack0", n_ack0 - k0, 32'd0);
        step();

        // reset while the func unit is still busy
        fu_lat = 20;
        a0 = 8'd9; b0 = 8'd1; req0 = 1'b1;
        wait_start(got);
        chk("rstmid_start", {31'd0, got}, 32'd1);
        req0 = 1'b0;
        step();
        step();
        step();
        k0 = n_ack0;
        rst = 1'b1;
        step();
        chk("rstmid_ctl", {26'd0, ack0, ack1, err0, err1, busy,
                           fu_if.fu_start_o}, 32'd0);
        chk("rstmid_y", {y1, y0}, 32'd0);
        chk("rstmid_fu_ab", {16'd0, fu_if.fu_a_bo, fu_if.fu_b_bo},
            32'd0);
        rst = 1'b0;
        fu_lat = 2;
        repeat (30) step();
        chk("rstmid_no_ack", n_ack0 - k0, 32'd0);
        a0 = 8'd0; b0 = 8'd0; req0 = 1'b1;
        wait_port(0, got, cyc);
        req0 = 1'b0;
        chk("zero_ack", {31'd0, got}, 32'd1);
        chk("zero_y0", {16'd0, y0}, 32'd0);
        step();

        // nonzero y0 before the dead func unit test
        a0 = 8'd2; b0 = 8'd8; req0 = 1'b1;
        wait_port(0, got, cyc);
        req0 = 1'b0;
        chk("pre_to_y0", {16'd0, y0}, 32'd6);
        step();

        // func unit never answers
        fu_dead = 1'b1;
        k0 = n_ack0;
        k1 = n_err0;
        a0 = 8'd7; b0 = 8'd8; req0 = 1'b1;
        wait_start(got);
        chk("to_start", {31'd0, got}, 32'd1);
        req0 = 1'b0;
`ifdef FUNC_SCHED_TIMEOUT_EN
        wait_port(0, got, cyc);
        chk("to_ack", {31'd0, got}, 32'd1);
        chk("to_cycles", cyc, 32'd11);
        chk("to_err", {31'd0, err0}, 32'd1);
        chk("to_y0_held", {16'd0, y0}, 32'd6);
        step();
        chk("to_idle", {31'd0, busy}, 32'd0);
`else
        repeat (40) step();
        chk("noto_no_ack", n_ack0 - k0, 32'd0);
        chk("noto_no_err", n_err0 - k1, 32'd0);
        chk("noto_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        fu_dead = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
